regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL expose parameter FAIR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to requester A.
REQ-002 The block SHALL expose port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL expose port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL expose port a_valid, input, 1 bit: requester A (ALU writeback) has a write pending.
REQ-005 The block SHALL expose port a_dest, input, 5 bits: requester A destination register index.
REQ-006 The block SHALL expose port a_data, input, 32 bits: requester A write data.
REQ-007 The block SHALL expose port a_ready, output, 1 bit: A's request is accepted this cycle.
REQ-008 The block SHALL expose ports b_valid, b_dest, b_data and b_ready, with widths 1/5/32/1 and directions in/in/in/out: the same handshake for requester B (memory-load writeback).
REQ-009 The block SHALL expose port rf_load, output, 1 bit: registered write enable to the register file.
REQ-010 The block SHALL expose port rf_dest, output, 5 bits: registered write index to the register file.
REQ-011 The block SHALL expose port rf_in, output, 32 bits: registered write data to the register file.
REQ-012 The block SHALL expose port conflict_cnt, output, 16 bits: count of cycles in which a valid, non-x0 request was denied.

Function
REQ-013 Transfer: a request SHALL transfer when x_valid && x_ready; a_ready and b_ready are combinational in the current cycle's valids, dests and arbitration state.
REQ-014 Requester rule: a requester SHALL hold its valid, dest and data stable from valid assertion until ready; the bench treats a violation as a requester error, with block behaviour undefined.
REQ-015 x0 requests: a valid request with dest == 0 SHALL be accepted immediately (ready = 1), SHALL NOT consume the write port, and SHALL NOT produce rf_load.
REQ-016 Single contender: if exactly one non-x0 request is valid, that requester SHALL be granted.
REQ-017 Both contending, FAIR = 1: the requester not granted most recently SHALL win.
REQ-018 Both contending, FAIR = 0: A SHALL always win.
REQ-019 Pointer: the last-grant pointer SHALL update only on a non-x0 grant; x0 acceptances and idle cycles leave it unchanged.
REQ-020 Write latency: one cycle after a non-x0 transfer, rf_load SHALL be 1, with rf_dest/rf_in equal to the transferred dest/data.
REQ-021 Idle: in any cycle following no non-x0 transfer, rf_load SHALL be 0 and rf_dest/rf_in SHALL hold their previous values.
REQ-022 Port limit: at most one non-x0 transfer SHALL occur per cycle.
REQ-023 Mixed x0: an x0 acceptance on one requester MAY coincide with a non-x0 grant on the other.
REQ-024 Same dest: when A and B target the same non-x0 index, writes SHALL be issued in grant order on consecutive cycles, so the later-granted data is final.
REQ-025 Fairness bound: with FAIR = 1 and both requesters continuously valid, grants SHALL alternate, and no requester waits more than 1 cycle.
REQ-026 Counter: conflict_cnt SHALL increment by 1 in each cycle where a valid, non-x0 request receives ready = 0.
REQ-027 Counter saturation: conflict_cnt SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-028 Outputs at reset: while rst = 1, regardless of clk, rf_load, rf_dest, rf_in and conflict_cnt SHALL be 0.
REQ-029 Pointer at reset: while rst = 1, the last-grant pointer SHALL be set to B, so A wins the first contention.
REQ-030 Ready at reset: a_ready and b_ready SHALL be 0 while rst = 1, so no request is consumed during reset.
REQ-031 Mid-operation reset: asserting rst mid-operation SHALL discard a write scheduled for the next cycle, with rf_load = 0 immediately; a requester still valid after rst deasserts SHALL be served normally.

Verification
REQ-032 Single write: A writes dest 5, data 32'hDEADBEEF with B idle -> a_ready = 1 the same cycle; next cycle rf_load = 1, rf_dest = 5, rf_in = 32'hDEADBEEF.
REQ-033 Sustained contention: A (dest 3, data 1) and B (dest 4, data 2) valid continuously after reset, FAIR = 1 -> grants A, B, A, B; conflict_cnt = 1 after the first contended cycle, then increments by 1 per contended cycle.
REQ-034 Fixed priority: FAIR = 0, both valid for 3 cycles, then A drops -> A granted 3 times, then B; conflict_cnt = 3.
REQ-035 x0 write: A dest 0 and B dest 7, data 9, same cycle -> a_ready = 1, b_ready = 1; next cycle rf_load = 1, rf_dest = 7; pointer = B.
REQ-036 Same dest: A and B both dest 10, data 32'h11 and 32'h22, from reset -> rf writes of 32'h11, then 32'h22 on consecutive cycles.
REQ-037 Reset and saturation: rst asserted the cycle after A's transfer -> rf_load = 0 asynchronously and conflict_cnt = 0; separately, conflict_cnt forced to 16'hFFFF with contention continuing -> conflict_cnt stays at 16'hFFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter in front of a single register-file write port.
// Requester A is the ALU writeback and requester B is the memory-load writeback.
// Writes to x0 are accepted at once and never use the port.
// The accepted non-x0 write reaches the register file one cycle later through registered outputs.
// conflict_cnt counts the cycles in which a real write was held off. It saturates instead of wrapping.
module regfile_wb_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_dest,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_dest,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        rf_load,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_in,
  output logic [15:0] conflict_cnt
);

  typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

  grant_e      last_grant_q, last_grant_d;
  logic        load_q, load_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] data_q, data_d;
  logic [15:0] conflict_q, conflict_d;

  logic a_req, b_req, grant_a, grant_b, denied;

  // Arbitration, handshake and next-state computation for the write port and counter
  always_comb begin
    a_req   = a_valid && (a_dest != 5'd0);
    b_req   = b_valid && (b_dest != 5'd0);
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_req && b_req) begin
      // On contention, A wins in fixed mode, or in fair mode when B had the port last
      if (FAIR == 0 || last_grant_q == GRANT_B) grant_a = 1'b1;
      else                                      grant_b = 1'b1;
    end else begin
      grant_a = a_req;
      grant_b = b_req;
    end
    // While reset is held nothing is accepted
    if (rst) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
    a_ready = !rst && ((a_valid && a_dest == 5'd0) || grant_a);
    b_ready = !rst && ((b_valid && b_dest == 5'd0) || grant_b);

    // The pointer moves only when a real write takes the port
    last_grant_d = last_grant_q;
    if (grant_a) last_grant_d = GRANT_A;
    if (grant_b) last_grant_d = GRANT_B;

    load_d = grant_a || grant_b;
    dest_d = dest_q;
    data_d = data_q;
    if (grant_a) begin
      dest_d = a_dest;
      data_d = a_data;
    end else if (grant_b) begin
      dest_d = b_dest;
      data_d = b_data;
    end

    denied     = (a_req && !a_ready) || (b_req && !b_ready);
    conflict_d = conflict_q;
    if (denied && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
  end

  // State registers; reset clears the port and counter and points at B so A wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GRANT_B;
      load_q       <= 1'b0;
      dest_q       <= 5'd0;
      data_q       <= 32'd0;
      conflict_q   <= 16'd0;
    end else begin
      last_grant_q <= last_grant_d;
      load_q       <= load_d;
      dest_q       <= dest_d;
      data_q       <= data_d;
      conflict_q   <= conflict_d;
    end
  end

  assign rf_load      = load_q;
  assign rf_dest      = dest_q;
  assign rf_in        = data_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter.
// It drives one fair instance and one fixed-priority instance from the same inputs.
// A rule-level model of the arbiter runs for each instance, alongside a vector table and directed sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_dest = '0, b_dest = '0;
  logic [31:0] a_data = '0, b_data = '0;

  logic [1:0]  a_ready_w, b_ready_w, rf_load_w;
  logic [4:0]  rf_dest_w [2];
  logic [31:0] rf_in_w [2];
  logic [15:0] cnt_w [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.FAIR(0)) dut0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready_w[0]),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready_w[0]),
    .rf_load(rf_load_w[0]), .rf_dest(rf_dest_w[0]), .rf_in(rf_in_w[0]),
    .conflict_cnt(cnt_w[0])
  );

  regfile_wb_arbiter #(.FAIR(1)) dut1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready_w[1]),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready_w[1]),
    .rf_load(rf_load_w[1]), .rf_dest(rf_dest_w[1]), .rf_in(rf_in_w[1]),
    .conflict_cnt(cnt_w[1])
  );

  // Reference model state, indexed by the FAIR value of the instance
  bit          m_lastb [2];   // 1 when B took the port most recently
  logic        m_load  [2];
  logic [4:0]  m_dest  [2];
  logic [31:0] m_data  [2];
  int          m_cnt   [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < 2; f++) begin
      m_lastb[f] = 1'b1;
      m_load[f]  = 1'b0;
      m_dest[f]  = '0;
      m_data[f]  = '0;
      m_cnt[f]   = 0;
    end
  endtask

  task automatic chk_outputs(input int f, input string tag);
    chk($sformatf("%s f%0d rf_load", tag, f), {31'd0, rf_load_w[f]}, {31'd0, m_load[f]});
    chk($sformatf("%s f%0d rf_dest", tag, f), {27'd0, rf_dest_w[f]}, {27'd0, m_dest[f]});
    chk($sformatf("%s f%0d rf_in", tag, f), rf_in_w[f], m_data[f]);
    chk($sformatf("%s f%0d conflict_cnt", tag, f), {16'd0, cnt_w[f]}, m_cnt[f]);
  endtask

  // Hold reset across one clock edge with a request pending.
  // Outputs must stay cleared and nothing may be accepted during that time.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b1; a_dest = 5'd5; a_data = 32'h1234;
    b_valid = 1'b1; b_dest = 5'd6; b_data = 32'h5678;
    model_reset();
    #1;
    for (int f = 0; f < 2; f++) begin
      chk_outputs(f, "reset");
      chk($sformatf("reset f%0d a_ready", f), {31'd0, a_ready_w[f]}, 32'd0);
      chk($sformatf("reset f%0d b_ready", f), {31'd0, b_ready_w[f]}, 32'd0);
    end
    @(posedge clk); #1;
    for (int f = 0; f < 2; f++) chk_outputs(f, "reset_edge");
    @(negedge clk);
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  // Run one clock cycle. Inputs are driven at the falling edge and readies are checked 1 ns later.
  // Registered outputs are checked 1 ns after the rising edge.
  task automatic step(input logic av, input logic [4:0] ad, input logic [31:0] adt,
                      input logic bv, input logic [4:0] bd, input logic [31:0] bdt,
                      input logic [1:0] mask, input int sel,
                      output logic mra, output logic mrb, output logic dra, output logic drb);
    logic ga [2], gb [2], ra [2], rb [2];
    bit aw, bw;
    @(negedge clk);
    a_valid = av; a_dest = ad; a_data = adt;
    b_valid = bv; b_dest = bd; b_data = bdt;
    #1;
    aw = av && (ad != 0);
    bw = bv && (bd != 0);
    for (int f = 0; f < 2; f++) begin
      if (aw && bw) begin
        ga[f] = (f == 0) || m_lastb[f];
        gb[f] = !ga[f];
      end else begin
        ga[f] = aw;
        gb[f] = bw;
      end
      ra[f] = (av && ad == 0) || ga[f];
      rb[f] = (bv && bd == 0) || gb[f];
      if (mask[f]) begin
        chk($sformatf("f%0d a_ready", f), {31'd0, a_ready_w[f]}, {31'd0, ra[f]});
        chk($sformatf("f%0d b_ready", f), {31'd0, b_ready_w[f]}, {31'd0, rb[f]});
      end
    end
    mra = ra[sel]; mrb = rb[sel];
    dra = a_ready_w[sel]; drb = b_ready_w[sel];
    @(posedge clk);
    for (int f = 0; f < 2; f++) begin
      if ((aw && !ra[f]) || (bw && !rb[f]))
        if (m_cnt[f] < 65535) m_cnt[f]++;
      m_load[f] = ga[f] || gb[f];
      if (ga[f]) begin
        m_lastb[f] = 1'b0; m_dest[f] = ad; m_data[f] = adt;
      end else if (gb[f]) begin
        m_lastb[f] = 1'b1; m_dest[f] = bd; m_data[f] = bdt;
      end
    end
    #1;
    for (int f = 0; f < 2; f++) if (mask[f]) chk_outputs(f, "cycle");
  endtask

  // Random traffic that keeps each request stable until the selected instance accepts it
  task automatic rand_phase(input int sel, input int n);
    logic pav, pbv, mra, mrb, dra, drb;
    logic [4:0] pad, pbd;
    logic [31:0] padt, pbdt;
    logic [1:0] m;
    m = (sel == 0) ? 2'b01 : 2'b10;
    pav = 1'b0; pbv = 1'b0; pad = '0; pbd = '0; padt = '0; pbdt = '0;
    for (int i = 0; i < n; i++) begin
      if (!pav) begin
        pav = ($urandom_range(0, 3) != 0); pad = 5'($urandom_range(0, 7)); padt = $urandom;
      end
      if (!pbv) begin
        pbv = ($urandom_range(0, 3) != 0); pbd = 5'($urandom_range(0, 7)); pbdt = $urandom;
      end
      step(pav, pad, padt, pbv, pbd, pbdt, m, sel, mra, mrb, dra, drb);
      if (mra) pav = 1'b0;
      if (mrb) pbv = 1'b0;
    end
  endtask

  typedef struct {
    logic av; logic [4:0] ad; logic [31:0] adt;
    logic bv; logic [4:0] bd; logic [31:0] bdt;
    logic ea; logic eb; logic eload; logic [4:0] edest; logic [31:0] edata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic mra, mrb, dra, drb;

    // Expected readies and registered port for the FAIR=1 instance, starting from reset
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h55,       1'b1, 5'd7,  32'd9,  1'b1, 1'b1, 1'b1, 5'd7,  32'd9};
    vecs[3] = '{1'b1, 5'd3,  32'd1,        1'b1, 5'd4,  32'd2,  1'b1, 1'b0, 1'b1, 5'd3,  32'd1};
    vecs[4] = '{1'b1, 5'd3,  32'd1,        1'b1, 5'd4,  32'd2,  1'b0, 1'b1, 1'b1, 5'd4,  32'd2};
    vecs[5] = '{1'b1, 5'd3,  32'd1,        1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b1, 5'd3,  32'd1};
    vecs[6] = '{1'b1, 5'd10, 32'h11,       1'b1, 5'd10, 32'h22, 1'b0, 1'b1, 1'b1, 5'd10, 32'h22};
    vecs[7] = '{1'b1, 5'd10, 32'h11,       1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 1'b1, 5'd10, 32'h11};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h33, 1'b0, 1'b1, 1'b0, 5'd10, 32'h11};
    vecs[9] = '{1'b1, 5'd8,  32'h80,       1'b1, 5'd9,  32'h90, 1'b0, 1'b1, 1'b1, 5'd9,  32'h90};

    model_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].av, vecs[i].ad, vecs[i].adt, vecs[i].bv, vecs[i].bd, vecs[i].bdt,
           2'b11, 1, mra, mrb, dra, drb);
      chk($sformatf("vec%0d a_ready", i), {31'd0, dra}, {31'd0, vecs[i].ea});
      chk($sformatf("vec%0d b_ready", i), {31'd0, drb}, {31'd0, vecs[i].eb});
      chk($sformatf("vec%0d rf_load", i), {31'd0, rf_load_w[1]}, {31'd0, vecs[i].eload});
      chk($sformatf("vec%0d rf_dest", i), {27'd0, rf_dest_w[1]}, {27'd0, vecs[i].edest});
      chk($sformatf("vec%0d rf_in", i), rf_in_w[1], vecs[i].edata);
      $display("vec %0d: a_ready=%0b b_ready=%0b rf_load=%0b rf_dest=%0d rf_in=%0h",
               i, dra, drb, rf_load_w[1], rf_dest_w[1], rf_in_w[1]);
    end

    // Sustained contention in fair mode: grants alternate A, B, A, B
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2, 2'b11, 1, mra, mrb, dra, drb);
      chk($sformatf("alt%0d a_ready", k), {31'd0, dra}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d b_ready", k), {31'd0, drb}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d conflict_cnt", k), {16'd0, cnt_w[1]}, k + 1);
      $display("alt %0d: a_ready=%0b b_ready=%0b cnt=%0d", k, dra, drb, cnt_w[1]);
    end

    // Fixed priority: A wins three times, then B is served once A drops
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2, 2'b11, 0, mra, mrb, dra, drb);
      chk($sformatf("fix%0d a_ready", k), {31'd0, dra}, 32'd1);
    end
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd2, 2'b11, 0, mra, mrb, dra, drb);
    chk("fix b_ready", {31'd0, drb}, 32'd1);
    chk("fix conflict_cnt", {16'd0, cnt_w[0]}, 32'd3);
    chk("fix rf_dest", {27'd0, rf_dest_w[0]}, 32'd4);
    $display("fixed: b granted, cnt=%0d", cnt_w[0]);

    // Same destination: the two writes land on consecutive cycles in grant order
    do_reset();
    step(1'b1, 5'd10, 32'h11, 1'b1, 5'd10, 32'h22, 2'b11, 1, mra, mrb, dra, drb);
    chk("same first rf_in", rf_in_w[1], 32'h11);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h22, 2'b11, 1, mra, mrb, dra, drb);
    chk("same second rf_in", rf_in_w[1], 32'h22);
    chk("same second rf_load", {31'd0, rf_load_w[1]}, 32'd1);
    $display("same dest: final rf_in=%0h", rf_in_w[1]);

    // Reset asserted between clock edges, just after a write was registered
    do_reset();
    step(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2, 2'b11, 1, mra, mrb, dra, drb);
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 2'b11, 1, mra, mrb, dra, drb);
    chk("pre_rst rf_load", {31'd0, rf_load_w[1]}, 32'd1);
    #2;
    rst = 1'b1;
    a_valid = 1'b1; a_dest = 5'd6; a_data = 32'h66;
    #1;
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("async f%0d rf_load", f), {31'd0, rf_load_w[f]}, 32'd0);
      chk($sformatf("async f%0d conflict_cnt", f), {16'd0, cnt_w[f]}, 32'd0);
      chk($sformatf("async f%0d a_ready", f), {31'd0, a_ready_w[f]}, 32'd0);
    end
    @(posedge clk); #1;
    chk("async edge rf_load", {31'd0, rf_load_w[1]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0, 2'b11, 1, mra, mrb, dra, drb);
    chk("post_rst rf_in", rf_in_w[1], 32'h66);
    $display("async reset: served after release, rf_in=%0h", rf_in_w[1]);

    // Saturation: continuous contention beyond 65535 cycles
    do_reset();
    @(negedge clk);
    a_valid = 1'b1; a_dest = 5'd3; a_data = 32'd1;
    b_valid = 1'b1; b_dest = 5'd4; b_data = 32'd2;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat f0 conflict_cnt", {16'd0, cnt_w[0]}, 32'hFFFF);
    chk("sat f1 conflict_cnt", {16'd0, cnt_w[1]}, 32'hFFFF);
    @(posedge clk); #1;
    chk("sat hold f0 conflict_cnt", {16'd0, cnt_w[0]}, 32'hFFFF);
    chk("sat hold f1 conflict_cnt", {16'd0, cnt_w[1]}, 32'hFFFF);
    $display("saturation: cnt0=%0h cnt1=%0h", cnt_w[0], cnt_w[1]);

    // Random traffic checked against the model for each arbitration mode
    do_reset();
    rand_phase(1, 400);
    do_reset();
    rand_phase(0, 400);
    $display("random phases done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
